ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 113 +++++++++++
 tb/tb_ram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter with lock that shares one synchronous block RAM.
// Grants are combinational in the request cycle; read data returns one cycle later; losers stall on req.
module ram_arbiter #(
    parameter int DATA = 8,
    parameter int ADDR = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            wr0,
    input  logic            wr1,
    input  logic            lock0,
    input  logic            lock1,
    input  logic [ADDR-1:0] addr0,
    input  logic [ADDR-1:0] addr1,
    input  logic [DATA-1:0] wdata0,
    input  logic [DATA-1:0] wdata1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [DATA-1:0] rdata0,
    output logic [DATA-1:0] rdata1,
    output logic [ADDR-1:0] ram_addr,
    output logic            ram_wr,
    output logic [DATA-1:0] ram_din,
    input  logic [DATA-1:0] ram_dout
);

    logic last_q,    last_d;
    logic owner_q,   owner_d;
    logic owned_q,   owned_d;
    logic rvalid0_q, rvalid0_d;
    logic rvalid1_q, rvalid1_d;

    logic hold;
    logic win0;
    logic win1;

    // A locked owner that is still requesting pre-empts round-robin entirely.
    always_comb begin
        hold = owned_q & (owner_q ? req1 : req0);
        if (hold) begin
            win0 = ~owner_q;
            win1 = owner_q;
        end else begin
            win0 = req0 & (~req1 | last_q);
            win1 = req1 & (~req0 | ~last_q);
        end
    end

    // Gating with rst drops grants asynchronously while reset is held.
    assign gnt0 = win0 & rst;
    assign gnt1 = win1 & rst;

    always_comb begin
        ram_addr = '0;
        ram_wr   = 1'b0;
        ram_din  = '0;
        if (gnt0) begin
            ram_addr = addr0;
            ram_wr   = wr0;
            ram_din  = wdata0;
        end else if (gnt1) begin
            ram_addr = addr1;
            ram_wr   = wr1;
            ram_din  = wdata1;
        end
    end

    always_comb begin
        last_d    = last_q;
        owner_d   = owner_q;
        owned_d   = owned_q;
        rvalid0_d = gnt0 & ~wr0;
        rvalid1_d = gnt1 & ~wr1;
        if (gnt0) begin
            last_d  = 1'b0;
            owner_d = 1'b0;
            owned_d = lock0;
        end else if (gnt1) begin
            last_d  = 1'b1;
            owner_d = 1'b1;
            owned_d = lock1;
        end else if (owned_q & ~hold) begin
            owned_d = 1'b0;
        end
    end

    // last resets to 1 so that requester 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            owned_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            owner_q   <= owner_d;
            owned_q   <= owned_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = ram_dout;
    assign rdata1  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations plus random traffic
// checked every cycle against a rule-level arbitration model and a reference memory.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req  = '0;
    logic [1:0] wr   = '0;
    logic [1:0] lock = '0;
    logic [7:0] addr  [2] = '{default: 8'h00};
    logic [7:0] wdata [2] = '{default: 8'h00};

    logic       gnt0, gnt1, rvalid0, rvalid1, ram_wr;
    logic [7:0] rdata0, rdata1, ram_addr, ram_din;
    logic [7:0] ram_dout = 8'h00;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA(8), .ADDR(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]),
        .wr0(wr[0]), .wr1(wr[1]),
        .lock0(lock[0]), .lock1(lock[1]),
        .addr0(addr[0]), .addr1(addr[1]),
        .wdata0(wdata[0]), .wdata1(wdata[1]),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // Synchronous block RAM attached to the arbiter.
    logic [7:0] ram [256] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Rule-level model: who should win, plus a reference memory image.
    int         m_last  = 1;
    bit         m_owned = 1'b0;
    int         m_owner = 0;
    bit  [1:0]  exp_rv  = '0;
    logic [7:0] exp_rd  = 8'h00;
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    function automatic int winner();
        if (!rst) return -1;
        if (m_owned && req[m_owner]) return m_owner;
        if (req[0] && req[1]) return 1 - m_last;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        int w;
        if (!rst) begin
            m_last = 1; m_owned = 1'b0; m_owner = 0; exp_rv = '0;
        end else begin
            w = winner();
            exp_rv = '0;
            if (w >= 0) begin
                if (wr[w]) ref_mem[addr[w]] = wdata[w];
                else begin
                    exp_rv[w] = 1'b1;
                    exp_rd    = ref_mem[addr[w]];
                end
                m_last = w; m_owned = lock[w]; m_owner = w;
            end else if (m_owned && !req[m_owner]) begin
                m_owned = 1'b0;
            end
        end
    end

    bit chk_en = 1'b0;
    bit [1:0] g_seen = '0;
    int waitc [2] = '{0, 0};
    int cw;

    always @(negedge clk) begin
        if (chk_en) begin
            cw = winner();
            check("gnt0", int'(gnt0), int'(cw == 0));
            check("gnt1", int'(gnt1), int'(cw == 1));
            check("both_gnt", int'(gnt0 & gnt1), 0);
            check("ram_wr", int'(ram_wr), cw >= 0 ? int'(wr[cw]) : 0);
            check("ram_addr", int'(ram_addr), cw >= 0 ? int'(addr[cw]) : 0);
            check("ram_din", int'(ram_din), cw >= 0 ? int'(wdata[cw]) : 0);
            check("rvalid0", int'(rvalid0), int'(exp_rv[0]));
            check("rvalid1", int'(rvalid1), int'(exp_rv[1]));
            if (exp_rv[0]) check("rdata0", int'(rdata0), int'(exp_rd));
            if (exp_rv[1]) check("rdata1", int'(rdata1), int'(exp_rd));
            g_seen = {gnt1, gnt0};
            for (int i = 0; i < 2; i++) begin
                if (!rst || !req[i] || g_seen[i] || (m_owned && m_owner == 1 - i && req[1-i]))
                    waitc[i] = 0;
                else begin
                    waitc[i]++;
                    check("wait_bound", int'(waitc[i] > 1), 0);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int g_exp  [4] = '{0, 1, 0, 1};
    int rv0_exp[4] = '{0, 1, 0, 1};
    int rv1_exp[4] = '{0, 0, 1, 0};

    initial begin
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Reset holds grants low even with both requesting.
        req = 2'b11; wr = 2'b00; addr[0] = 8'h01; addr[1] = 8'h02;
        cyc(); cyc();
        @(negedge clk);
        check("rst_gnt0", int'(gnt0), 0);
        check("rst_gnt1", int'(gnt1), 0);
        check("rst_ram_wr", int'(ram_wr), 0);
        check("rst_rvalid0", int'(rvalid0), 0);
        check("rst_rvalid1", int'(rvalid1), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Both read continuously: grants alternate from requester 0.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_gnt0", int'(gnt0), int'(g_exp[k] == 0));
            check("rr_gnt1", int'(gnt1), int'(g_exp[k] == 1));
            check("rr_rvalid0", int'(rvalid0), rv0_exp[k]);
            check("rr_rvalid1", int'(rvalid1), rv1_exp[k]);
            cyc();
        end
        req = 2'b00;
        @(negedge clk);
        check("rr_last_rvalid1", int'(rvalid1), 1);
        cyc();

        // Write then read-back of the same address by the other requester.
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 8'h10; wdata[0] = 8'h5A;
        @(negedge clk);
        check("wr_gnt0", int'(gnt0), 1);
        check("wr_ram_wr", int'(ram_wr), 1);
        check("wr_ram_addr", int'(ram_addr), 8'h10);
        check("wr_ram_din", int'(ram_din), 8'h5A);
        cyc();
        req[0] = 1'b0; wr[0] = 1'b0;
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 8'h10;
        @(negedge clk);
        check("rd_gnt1", int'(gnt1), 1);
        check("rd_ram_addr", int'(ram_addr), 8'h10);
        cyc();
        req[1] = 1'b0;
        @(negedge clk);
        check("rd_rvalid1", int'(rvalid1), 1);
        check("rd_rdata1", int'(rdata1), 8'h5A);
        cyc();

        // Locked requester 0 keeps three consecutive grants against requester 1.
        req = 2'b11; wr = 2'b00; lock[0] = 1'b1; addr[0] = 8'h03; addr[1] = 8'h04;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) lock[0] = 1'b0;
            @(negedge clk);
            check("lock_gnt0", int'(gnt0), 1);
            check("lock_gnt1", int'(gnt1), 0);
            cyc();
        end
        @(negedge clk);
        check("unlock_gnt1", int'(gnt1), 1);
        cyc();
        req = 2'b00;
        cyc();

        // Idle: RAM port parked at zero, nothing granted or returned.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_ram_wr", int'(ram_wr), 0);
            check("idle_ram_addr", int'(ram_addr), 0);
            check("idle_gnt", int'({gnt1, gnt0}), 0);
            check("idle_rvalid", int'({rvalid1, rvalid0}), 0);
            cyc();
        end

        // Reset mid-cycle after a read grant.
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 8'h10;
        @(negedge clk);
        check("r38_gnt0_pre", int'(gnt0), 1);
        #2 rst = 1'b0;
        #1;
        check("r38_gnt0_async", int'(gnt0), 0);
        check("r38_ram_wr", int'(ram_wr), 0);
        @(negedge clk);
        check("r38_rvalid0", int'(rvalid0), 0);
        req = 2'b11; wr = 2'b00;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("r38_tie_gnt0", int'(gnt0), 1);
        check("r38_tie_gnt1", int'(gnt1), 0);
        cyc();
        req = 2'b00;
        cyc();

        // Random traffic; a request is held with its attributes until granted.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || g_seen[i]) begin
                    req[i]   = ($urandom_range(0, 99) < 60);
                    wr[i]    = 1'($urandom_range(0, 1));
                    addr[i]  = 8'($urandom_range(0, 15));
                    wdata[i] = 8'($urandom);
                    lock[i]  = ($urandom_range(0, 3) == 0);
                end
            end
            cyc();
        end
        req = 2'b00;
        cyc(); cyc();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
